// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT widths, complex sample type, bit reversal and read-FSM states
// FFT_ADDR_W : log2 of the FFT frame length (stage count)
// FFT_DATA_W : packed complex sample width {re, im}
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 3
`endif
`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif
package fft_pkg;
    localparam int FFT_ADDR_W = `TOTAL_STAGE;
    localparam int FFT_DATA_W = `CPLX_WIDTH;

    typedef struct packed {
        logic signed [FFT_DATA_W/2-1:0] re;
        logic signed [FFT_DATA_W/2-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

    // reverse the low w bits of addr: full 32-bit reversal, then drop the unused tail
    function automatic logic [31:0] bitrev(input logic [31:0] addr, input int w);
        logic [31:0] r;
        r = {<<{addr}};
        return r >> (32 - w);
    endfunction
endpackage

// File: rtl/fft_out_reorder_if.sv
// fft_out_reorder_if: FFT-side write stream plus valid/ready natural-order output stream
// ien/iaddr/idata         : sample from the last FFT stage, no back-pressure
// ovalid/oready           : output handshake
// oaddr/odata/olast       : natural-order bin, its sample, high on bin N-1
// ovf                     : sticky drop flag
interface fft_out_reorder_if #(
    parameter int ADDR_W = fft_pkg::FFT_ADDR_W,
    parameter int DATA_W = fft_pkg::FFT_DATA_W
);
    logic              ien;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] idata;
    logic              ovalid;
    logic              oready;
    logic [ADDR_W-1:0] oaddr;
    logic [DATA_W-1:0] odata;
    logic              olast;
    logic              ovf;

    modport master (output ien, iaddr, idata, oready, input ovalid, oaddr, odata, olast, ovf);
    modport slave  (input ien, iaddr, idata, oready, output ovalid, oaddr, odata, olast, ovf);
endinterface

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, depth 2*N addressed {bank, index}, registered read, no reset
// iclk          : clock
// we/waddr/wdata: write port
// re/raddr/rdata: read port, rdata valid the cycle after re
module fft_reorder_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              iclk,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W:0]   raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

    always_ff @(posedge iclk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong capture of FFT output frames, replayed in natural order on valid/ready
// iclk : clock
// rst  : asynchronous active-high reset
// bus  : slave side of fft_out_reorder_if (write stream in, output stream and ovf out)
module fft_out_reorder import fft_pkg::*; #(
    parameter int ADDR_W  = FFT_ADDR_W,
    parameter int DATA_W  = FFT_DATA_W,
    parameter bit BIT_REV = 1'b1
) (
    input logic              iclk,
    input logic              rst,
    fft_out_reorder_if.slave bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] k;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    rd_state_t         state, state_nx;
    logic              wr_bank, rd_bank, iss_bank;
    logic [1:0]        bank_full, set_mask, clr_mask;
    logic [ADDR_W-1:0] wcnt, rcnt, pend_k, wr_idx;
    logic              pend, pend_last;
    beat_t             skid [2];
    logic              wp, rp;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] rdata;
    logic              wr_ok, wr_done, issue, pop, pop_last;

    assign wr_ok    = bus.ien && !bank_full[wr_bank];
    assign wr_done  = wr_ok && wcnt == '1;
    assign wr_idx   = BIT_REV ? ADDR_W'(bitrev(32'(bus.iaddr), ADDR_W)) : bus.iaddr;
    assign pop      = bus.ovalid && bus.oready;
    assign pop_last = pop && bus.olast;
    assign set_mask = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask = pop_last ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    // Reads run ahead into the next full bank so frames stream back to back;
    // a slot freed by this cycle's pop may be reused immediately.
    assign issue = bank_full[iss_bank] && (3'(cnt) + 3'(pend) - 3'(pop)) < 3'd2;

    assign bus.ovalid = cnt != 2'd0;
    assign bus.oaddr  = skid[rp].k;
    assign bus.odata  = skid[rp].data;
    assign bus.olast  = skid[rp].last;

    fft_reorder_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .iclk  (iclk),
        .we    (wr_ok),
        .waddr ({wr_bank, wr_idx}),
        .wdata (bus.idata),
        .re    (issue),
        .raddr ({iss_bank, rcnt}),
        .rdata (rdata)
    );

    always_comb begin
        state_nx = state;
        if (issue) state_nx = rcnt == '1 ? DRAIN : RUN;
        else if (state == DRAIN && pop_last) state_nx = IDLE;
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            iss_bank  <= 1'b0;
            bank_full <= 2'b00;
            wcnt      <= '0;
            rcnt      <= '0;
            pend      <= 1'b0;
            pend_k    <= '0;
            pend_last <= 1'b0;
            skid[0]   <= '0;
            skid[1]   <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= 2'd0;
            bus.ovf   <= 1'b0;
        end else begin
            state     <= state_nx;
            if (wr_ok) wcnt <= wcnt + 1'b1;
            if (wr_done) wr_bank <= ~wr_bank;
            if (bus.ien && bank_full[wr_bank]) bus.ovf <= 1'b1;
            bank_full <= (bank_full | set_mask) & ~clr_mask;
            if (pop_last) rd_bank <= ~rd_bank;
            if (issue) rcnt <= rcnt + 1'b1;
            if (issue && rcnt == '1) iss_bank <= ~iss_bank;
            pend      <= issue;
            pend_k    <= rcnt;
            pend_last <= rcnt == '1;
            if (pend) skid[wp] <= beat_t'{k: pend_k, data: rdata, last: pend_last};
            if (pend) wp <= ~wp;
            if (pop) rp <= ~rp;
            cnt       <= cnt + {1'b0, pend} - {1'b0, pop};
        end
    end
endmodule
